// File: rtl/alu_seq_exec.sv
// Handshaked RV32I execute unit: single-cycle ALU ops, iterative shifts and
// an optional shift-add multiplier. All outputs except oReady are registered.
module alu_seq_exec #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iFlush,
  input  logic            iValid,
  output logic            oReady,
  input  logic [1:0]      iALUOp,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic            oValid,
  input  logic            iReady,
  output logic [XLEN-1:0] oResult,
  output logic            oZero,
  output logic            oIllegal
);

  localparam int unsigned ShW = $clog2(XLEN);
  localparam int unsigned CntW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
  typedef enum logic [3:0] {
    OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd, OpMul, OpIll
  } op_e;

  // funct3 table shared by R-type (funct7 zero) and I-type.
  function automatic op_e f3_op(input logic [2:0] f3);
    unique case (f3)
      3'b000:  return OpAdd;
      3'b001:  return OpSll;
      3'b010:  return OpSlt;
      3'b011:  return OpSltu;
      3'b100:  return OpXor;
      3'b101:  return OpSrl;
      3'b110:  return OpOr;
      default: return OpAnd;
    endcase
  endfunction

  state_e          state_q, state_d;
  op_e             op_q, op_d, dec_op;
  logic [XLEN-1:0] opa_q, opa_d, opb_q, opb_d, acc_q, acc_d;
  logic [XLEN-1:0] res_q, res_d, one_res, step_res;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d, zero_q, zero_d, ill_q, ill_d;
  logic [ShW-1:0]  shamt;

  assign shamt = iB[ShW-1:0];

  // Decode the request fields into an internal op.
  always_comb begin
    dec_op = OpIll;
    unique case (iALUOp)
      2'b00: dec_op = OpAdd;
      2'b01: dec_op = OpSub;
      2'b10: begin
        if (funct7 == 7'b0000000) begin
          dec_op = f3_op(funct3);
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) dec_op = OpSub;
          else if (funct3 == 3'b101) dec_op = OpSra;
        end else if (funct7 == 7'b0000001 && funct3 == 3'b000 && ENABLE_M) begin
          dec_op = OpMul;
        end
      end
      default: begin
        if (funct3 == 3'b001) begin
          if (funct7 == 7'b0000000) dec_op = OpSll;
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0000000) dec_op = OpSrl;
          else if (funct7 == 7'b0100000) dec_op = OpSra;
        end else begin
          dec_op = f3_op(funct3);
        end
      end
    endcase
  end

  // Result of every op that completes straight from IDLE (shifts only by zero).
  always_comb begin
    one_res = '0;
    unique case (dec_op)
      OpAdd:                one_res = iA + iB;
      OpSub:                one_res = iA - iB;
      OpSlt:                one_res = {{(XLEN-1){1'b0}}, $signed(iA) < $signed(iB)};
      OpSltu:               one_res = {{(XLEN-1){1'b0}}, iA < iB};
      OpXor:                one_res = iA ^ iB;
      OpOr:                 one_res = iA | iB;
      OpAnd:                one_res = iA & iB;
      OpSll, OpSrl, OpSra:  one_res = iA;
      default:              one_res = '0;
    endcase
  end

  // Handshake FSM plus one iteration of the shift / multiply datapath.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    zero_d   = zero_q;
    ill_d    = ill_q;
    valid_d  = valid_q;
    step_res = '0;
    if (iFlush) begin
      state_d = StIdle;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (iValid) begin
            op_d  = dec_op;
            opa_d = iA;
            opb_d = iB;
            acc_d = '0;
            if (dec_op == OpMul) begin
              cnt_d   = CntW'(XLEN);
              state_d = StBusy;
            end else if ((dec_op == OpSll || dec_op == OpSrl || dec_op == OpSra) &&
                         shamt != '0) begin
              cnt_d   = CntW'(shamt);
              state_d = StBusy;
            end else begin
              res_d   = one_res;
              zero_d  = (one_res == '0);
              ill_d   = (dec_op == OpIll);
              valid_d = 1'b1;
              state_d = StDone;
            end
          end
        end
        StBusy: begin
          if (op_q == OpMul) begin
            step_res = opb_q[0] ? acc_q + opa_q : acc_q;
            acc_d    = step_res;
            opa_d    = opa_q << 1;
            opb_d    = opb_q >> 1;
          end else begin
            if (op_q == OpSll)      step_res = opa_q << 1;
            else if (op_q == OpSrl) step_res = opa_q >> 1;
            else                    step_res = {opa_q[XLEN-1], opa_q[XLEN-1:1]};
            opa_d = step_res;
          end
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            res_d   = step_res;
            zero_d  = (step_res == '0);
            ill_d   = 1'b0;
            valid_d = 1'b1;
            state_d = StDone;
          end
        end
        StDone: begin
          if (iReady) begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
      valid_q <= valid_d;
    end
  end

  assign oReady   = (state_q == StIdle);
  assign oValid   = valid_q;
  assign oResult  = res_q;
  assign oZero    = zero_q;
  assign oIllegal = ill_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: directed ops with literal expectations plus a
// latency/result model checked on every falling edge.
module tb_alu_seq_exec;

  logic        clk = 1'b0, rst_n = 1'b0, iFlush = 1'b0, iValid = 1'b0, iReady = 1'b0;
  logic [1:0]  iALUOp = '0;
  logic [6:0]  funct7 = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] iA = '0, iB = '0;
  logic        oReady, oValid, oZero, oIllegal;
  logic [31:0] oResult;
  logic        n_oReady, n_oValid, n_oZero, n_oIllegal;
  logic [31:0] n_oResult;

  int errors = 0;
  int checks = 0;

  alu_seq_exec #(.XLEN(32), .ENABLE_M(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .iFlush(iFlush), .iValid(iValid), .oReady(oReady),
    .iALUOp(iALUOp), .funct7(funct7), .funct3(funct3), .iA(iA), .iB(iB),
    .oValid(oValid), .iReady(iReady), .oResult(oResult), .oZero(oZero), .oIllegal(oIllegal)
  );

  // Same inputs, multiplier disabled: MUL encoding must be illegal here.
  alu_seq_exec #(.XLEN(32), .ENABLE_M(1'b0)) u_dut_nm (
    .clk(clk), .rst_n(rst_n), .iFlush(iFlush), .iValid(iValid), .oReady(n_oReady),
    .iALUOp(iALUOp), .funct7(funct7), .funct3(funct3), .iA(iA), .iB(iB),
    .oValid(n_oValid), .iReady(iReady), .oResult(n_oResult), .oZero(n_oZero),
    .oIllegal(n_oIllegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model op codes: 0 add 1 sub 2 sll 3 slt 4 sltu 5 xor 6 srl 7 sra 8 or 9 and 10 mul, -1 illegal
  function automatic int m_op(input logic [1:0] alu, input logic [6:0] f7, input logic [2:0] f3);
    int base[8];
    base = '{0, 2, 3, 4, 5, 6, 8, 9};
    if (alu == 2'd0) return 0;
    if (alu == 2'd1) return 1;
    if (alu == 2'd2) begin
      if (f7 == 7'h00) return base[f3];
      if (f7 == 7'h20) return (f3 == 3'd0) ? 1 : (f3 == 3'd5) ? 7 : -1;
      if (f7 == 7'h01 && f3 == 3'd0) return 10;
      return -1;
    end
    if (f3 == 3'd1) return (f7 == 7'h00) ? 2 : -1;
    if (f3 == 3'd5) return (f7 == 7'h00) ? 6 : (f7 == 7'h20) ? 7 : -1;
    return base[f3];
  endfunction

  function automatic logic [31:0] m_res(input int op, input logic [31:0] a, input logic [31:0] b);
    int k;
    k = int'(b[4:0]);
    case (op)
      0:       return a + b;
      1:       return a - b;
      2:       return a << k;
      3:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4:       return (a < b) ? 32'd1 : 32'd0;
      5:       return a ^ b;
      6:       return a >> k;
      7:       return $signed(a) >>> k;
      8:       return a | b;
      9:       return a & b;
      10:      return a * b;
      default: return 32'd0;
    endcase
  endfunction

  // Cycles from acceptance to the first cycle with oValid high.
  function automatic int m_lat(input int op, input logic [31:0] b);
    if (op == 2 || op == 6 || op == 7) return int'(b[4:0]) + 1;
    if (op == 10) return 33;
    return 1;
  endfunction

  function automatic int cur_op();
    return m_op(iALUOp, funct7, funct3);
  endfunction

  logic        m_busy, m_valid, m_ill;
  logic [31:0] m_r;
  int          m_due, cyc;

  // Model: when a request is accepted, schedule its result at the edge its latency implies.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_ill   <= 1'b0;
      m_r     <= '0;
      m_due   <= 0;
      cyc     <= 0;
    end else begin
      cyc <= cyc + 1;
      if (iFlush) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b0;
      end else if (m_valid) begin
        if (iReady) m_valid <= 1'b0;
      end else if (m_busy) begin
        if (cyc + 1 == m_due) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b1;
        end
      end else if (iValid) begin
        m_r   <= m_res(cur_op(), iA, iB);
        m_ill <= (cur_op() < 0);
        if (m_lat(cur_op(), iB) == 1) m_valid <= 1'b1;
        else begin
          m_busy <= 1'b1;
          m_due  <= cyc + m_lat(cur_op(), iB);
        end
      end
    end
  end

  // Compare the primary DUT against the model every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_ovalid", 32'(oValid), 32'(m_valid));
      chk("model_oready", 32'(oReady), 32'(!m_busy && !m_valid));
      if (m_valid) begin
        chk("model_result", oResult, m_r);
        chk("model_zero", 32'(oZero), 32'(m_r == 32'd0));
        chk("model_illegal", 32'(oIllegal), 32'(m_ill));
      end
    end
  end

  task automatic issue(input logic [1:0] alu, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    iALUOp = alu; funct7 = f7; funct3 = f3; iA = a; iB = b;
    iValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iValid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!oValid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume();
    iReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iReady = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] alu, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input logic exp_ill);
    int n;
    issue(alu, f7, f3, a, b);
    wait_valid(n);
    chk({name, "_lat"}, 32'(n), 32'(exp_lat));
    chk({name, "_res"}, oResult, exp_res);
    chk({name, "_zero"}, 32'(oZero), 32'(exp_res == 32'd0));
    chk({name, "_ill"}, 32'(oIllegal), 32'(exp_ill));
    consume();
    chk({name, "_ready_after"}, 32'(oReady), 32'd1);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_result", oResult, 32'd0);
    chk("rst_zero", 32'(oZero), 32'd0);
    chk("rst_ill", 32'(oIllegal), 32'd0);
    chk("rst_ready", 32'(oReady), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Leave a non-zero result behind, then reset in the middle of a multiply.
    run_op("add_pre", 2'b00, 7'h00, 3'd0, 32'h10, 32'h20, 32'h30, 1, 1'b0);
    issue(2'b10, 7'h01, 3'd0, 32'd7, 32'd9);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(oValid), 32'd0);
    chk("async_rst_result", oResult, 32'd0);
    chk("async_rst_ready", 32'(oReady), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add", 2'b00, 7'h00, 3'd0, 32'd5, 32'd7, 32'd12, 1, 1'b0);
    run_op("branch_sub", 2'b01, 7'h00, 3'd0, 32'h1234, 32'h1234, 32'h0, 1, 1'b0);
    run_op("r_sub", 2'b10, 7'h20, 3'd0, 32'h0, 32'h1, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("srai4", 2'b11, 7'h20, 3'd5, 32'h8000_0000, 32'd4, 32'hF800_0000, 5, 1'b0);
    run_op("srai0", 2'b11, 7'h20, 3'd5, 32'h8000_0000, 32'd0, 32'h8000_0000, 1, 1'b0);
    run_op("slt", 2'b10, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1'b0);
    run_op("sltu", 2'b10, 7'h00, 3'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b0);
    run_op("xor", 2'b10, 7'h00, 3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 1'b0);
    run_op("or", 2'b10, 7'h00, 3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1, 1'b0);
    run_op("and", 2'b10, 7'h00, 3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, 1'b0);
    run_op("srl31", 2'b10, 7'h00, 3'd5, 32'h8000_0000, 32'd31, 32'd1, 32, 1'b0);
    run_op("slli4", 2'b11, 7'h00, 3'd1, 32'd3, 32'd4, 32'h30, 5, 1'b0);
    run_op("addi_f7", 2'b11, 7'h7F, 3'd0, 32'd10, 32'hFFFF_FFFF, 32'd9, 1, 1'b0);
    run_op("ill_r", 2'b10, 7'h01, 3'd3, 32'd5, 32'd6, 32'd0, 1, 1'b1);
    run_op("ill_slli", 2'b11, 7'h20, 3'd1, 32'd5, 32'd6, 32'd0, 1, 1'b1);
    run_op("ill_srli", 2'b11, 7'h01, 3'd5, 32'd5, 32'd6, 32'd0, 1, 1'b1);

    // Multiply; the M-disabled instance reports it illegal on the next cycle.
    issue(2'b10, 7'h01, 3'd0, 32'hFFFF_FFFF, 32'd3);
    chk("nom_valid", 32'(n_oValid), 32'd1);
    chk("nom_ill", 32'(n_oIllegal), 32'd1);
    chk("nom_result", n_oResult, 32'd0);
    wait_valid(n);
    chk("mul_lat", 32'(n), 32'd33);
    chk("mul_res", oResult, 32'hFFFF_FFFD);
    for (int i = 0; i < 10; i++) begin
      iALUOp = 2'b00; iA = 32'd1; iB = 32'd2; iValid = 1'b1;
      @(negedge clk);
      chk("hold_res", oResult, 32'hFFFF_FFFD);
      chk("hold_valid", 32'(oValid), 32'd1);
      chk("hold_ready", 32'(oReady), 32'd0);
    end
    iValid = 1'b0;
    consume();
    chk("mul_ready_after", 32'(oReady), 32'd1);

    // Flush a long shift at N+5.
    issue(2'b10, 7'h00, 3'd1, 32'd1, 32'd20);
    repeat (4) @(negedge clk);
    iFlush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iFlush = 1'b0;
    chk("flush_ready", 32'(oReady), 32'd1);
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (oValid) n++;
    end
    chk("flush_no_valid", 32'(n), 32'd0);

    // Flush beats a simultaneous request in IDLE.
    iALUOp = 2'b00; iA = 32'd4; iB = 32'd4; iValid = 1'b1; iFlush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iValid = 1'b0; iFlush = 1'b0;
    chk("flush_vs_valid", 32'(oValid), 32'd0);
    @(negedge clk);
    chk("flush_vs_valid2", 32'(oValid), 32'd0);

    run_op("add_after_flush", 2'b00, 7'h00, 3'd0, 32'd1, 32'd1, 32'd2, 1, 1'b0);

    // Flush coinciding with consumption.
    issue(2'b00, 7'h00, 3'd0, 32'd3, 32'd4);
    wait_valid(n);
    chk("fc_res", oResult, 32'd7);
    iReady = 1'b1; iFlush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iReady = 1'b0; iFlush = 1'b0;
    chk("fc_ready", 32'(oReady), 32'd1);
    chk("fc_valid", 32'(oValid), 32'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
